dmux_stream: RTL and testbench

//  Registered 1-to-N demultiplexer with valid/ready handshake. Each input word

---
 rtl/dmux_stream.sv | 90 +++++++++
 tb/tb_dmux_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry output registers.
// Optional out-of-range drop counter is built when DMUX_STREAM_DROPCNT_EN is defined.
module dmux_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               bcast,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [7:0]         drop_cnt
);

  logic [N-1:0] free;
  logic [N-1:0] hit;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         accept;

  always_comb begin
    free = ~out_valid | out_ready;
    hit  = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = (sel == SELW'(i));
    end
    sel_ok = |hit;
    // Out-of-range words are always taken so they can be discarded without stalling.
    if (bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = |(free & hit);
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
    if (!accept) begin
      load = '0;
    end else if (bcast) begin
      load = {N{1'b1}};
    end else begin
      load = hit;
    end
  end

  // Stage p0: per-channel output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
          out_valid[i]               <= 1'b1;
        end else if (out_valid[i] && out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DMUX_STREAM_DROPCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] drop_cnt_p0;

  // Stage p0: saturating count of discarded out-of-range words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_p0 <= '0;
    end else if (accept && !bcast && !sel_ok) begin
      drop_cnt_p0 <= sat_inc(drop_cnt_p0);
    end
  end

  assign drop_cnt = drop_cnt_p0;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: directed scenarios plus randomized traffic checked
// every cycle against a per-channel slot model.
module tb_dmux_stream;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [SW-1:0]  sel = '0;
  logic           bcast = 1'b0;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '1;
  logic [7:0]     drop_cnt;

  logic           in_valid_b = 1'b0;
  logic           in_ready_b;
  logic [1:0]     sel_b = 2'd3;
  logic           bcast_b = 1'b0;
  logic [23:0]    out_data_b;
  logic [2:0]     out_valid_b;
  logic [2:0]     out_ready_b = 3'b111;
  logic [7:0]     drop_cnt_b;

  dmux_stream #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .bcast(bcast), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  dmux_stream #(.WIDTH(8), .N(3), .SELW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sel(sel_b), .bcast(bcast_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .drop_cnt(drop_cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel is a slot that is either empty or holds one word.
  bit         mvld[N];
  logic [W-1:0] mdat[N];
  int         mdrop = 0;
  int         bacc  = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      mvld[i] = 1'b0;
      mdat[i] = '0;
    end
  end

  function automatic bit m_free(int i);
    return !mvld[i] || out_ready[i];
  endfunction

  function automatic bit m_ready();
    if (bcast) begin
      for (int i = 0; i < N; i++) if (!m_free(i)) return 1'b0;
      return 1'b1;
    end
    if (int'(sel) < N) return m_free(int'(sel));
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_step
    bit acc;
    if (rst_n) begin
      acc = in_valid && m_ready();
      for (int i = 0; i < N; i++) begin
        if (acc && (bcast || int'(sel) == i)) begin
          mvld[i] = 1'b1;
          mdat[i] = in_data;
        end else if (mvld[i] && out_ready[i]) begin
          mvld[i] = 1'b0;
        end
      end
`ifdef DMUX_STREAM_DROPCNT_EN
      if (acc && !bcast && int'(sel) >= N && mdrop < 255) mdrop++;
`endif
      if (in_valid_b) bacc++;
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      mvld[i] = 1'b0;
      mdat[i] = '0;
    end
    mdrop = 0;
    bacc  = 0;
  end

  always @(negedge clk) begin : compare
    logic [N*W-1:0] ed;
    logic [N-1:0]   ev;
    for (int i = 0; i < N; i++) begin
      ev[i]        = mvld[i];
      ed[i*W +: W] = mdat[i];
    end
    chk("in_ready", in_ready, m_ready());
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
    chk("drop_cnt", drop_cnt, mdrop[7:0]);
    chk("b_in_ready", in_ready_b, 1);
    chk("b_out_valid", out_valid_b, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tbl[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] b_exp;

  initial begin
    // Reset held with a word presented
    in_valid = 1'b1;
    in_data  = 8'h77;
    sel      = 3'd0;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("first_valid", out_valid, 4'b0001);
    chk("first_data", out_data[7:0], 8'h77);

    // Routing on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      in_data = tbl[k];
      sel     = SW'(k);
      #1;
      chk("route_ready", in_ready, 1);
      step();
      chk("route_valid", out_valid, 4'b0001 << k);
      chk("route_lane", out_data[k*W +: W], tbl[k]);
    end
    in_valid = 1'b0;
    step();

    // Backpressure on channel 1
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    sel       = 3'd1;
    step();
    in_data = 8'h22;
    #1;
    chk("bp_ready_lo", in_ready, 0);
    step();
    chk("bp_hold_data", out_data[15:8], 8'h11);
    chk("bp_hold_valid", out_valid[1], 1);
    in_data = 8'h33;
    sel     = 3'd2;
    #1;
    chk("bp_other_ready", in_ready, 1);
    step();
    chk("bp_other_data", out_data[23:16], 8'h33);
    in_data   = 8'h22;
    sel       = 3'd1;
    out_ready = 4'b1111;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_release_data", out_data[15:8], 8'h22);
    chk("bp_release_valid", out_valid[1], 1);
    in_valid = 1'b0;
    step();

    // Broadcast, then blocked broadcast
    bcast    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    chk("bc_ready", in_ready, 1);
    step();
    chk("bc_valid", out_valid, 4'hF);
    chk("bc_data", out_data, {4{8'h5A}});
    in_valid  = 1'b0;
    out_ready = 4'b0111;
    step();
    chk("bc_ch3_held", out_valid, 4'b1000);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("bc_blocked_ready", in_ready, 0);
    step();
    chk("bc_blocked_valid", out_valid, 4'b1000);
    chk("bc_blocked_data", out_data, {4{8'h5A}});
    bcast     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'hF;
    step();

    // Randomized traffic including out-of-range sel values
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = W'($urandom);
      sel       = SW'($urandom % 8);
      bcast     = ($urandom % 8) == 0;
      out_ready = N'($urandom);
      step();
    end
    in_valid  = 1'b0;
    bcast     = 1'b0;
    out_ready = '1;
    step();

    // Out-of-range flood on the N=3 instance
    in_valid_b = 1'b1;
    repeat (300) step();
    in_valid_b = 1'b0;
    step();
`ifdef DMUX_STREAM_DROPCNT_EN
    b_exp = 8'd255;
`else
    b_exp = 8'd0;
`endif
    chk("b_drop_final", drop_cnt_b, b_exp);
    chk("b_drop_model", drop_cnt_b, b_exp == 8'd0 ? 0 : (bacc > 255 ? 255 : bacc));

    // Asynchronous reset between clock edges with ch0 and ch2 full
    out_ready = '0;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    sel       = 3'd0;
    step();
    in_data = 8'hC3;
    sel     = 3'd2;
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    step();
    rst_n     = 1'b1;
    out_ready = '1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
